csi_packet_parser_vc: RTL and testbench

- Parametrised CSI-2 packet parser for the receive path; sits between the D-PHY/lane-merge word stream and the pixel unpack/line buffer stage.
- Decodes the short/long packet header on each rising edge of I_hs_valid and extracts frame/line markers plus payload words.
- Supports up to NUM_VC virtual channels, with a per-VC frame state and line counter.
- Adds word-count rounding for any bus width, a payload last-word flag, truncation/sequence error detection, and an optional header ECC check.

---
 rtl/csi_packet_parser_vc.sv | 217 +++++++++++++++++++++
 tb/tb_csi_packet_parser_vc.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_packet_parser_vc.sv
// CSI-2 receive-path packet parser with per-virtual-channel frame/line tracking.
// Decodes short/long packet headers on the rising edge of I_hs_valid, emits frame
// markers, forwards payload words of the selected data type and flags truncation and
// frame-sequence errors. Optional header ECC check: define CSI_ECC_CHECK_EN.
module csi_packet_parser_vc #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_VC  = 4,
    parameter logic [5:0]  DATA_DT = 6'h2B,
    parameter int unsigned LCNT_W  = 16
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_hs_valid,
    input  logic [DATA_W-1:0] I_hs_data,
    input  logic [NUM_VC-1:0] I_vc_mask,
    output logic              O_frame_start,
    output logic              O_frame_end,
    output logic              O_line_start,
    output logic              O_valid,
    output logic [DATA_W-1:0] O_data,
    output logic              O_last,
    output logic [1:0]        O_vc,
    output logic [LCNT_W-1:0] O_line_cnt,
    output logic              O_err_trunc,
    output logic              O_err_seq
`ifdef CSI_ECC_CHECK_EN
    ,
    output logic              O_err_ecc
`endif
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned SHIFT = $clog2(BYTES);

    typedef enum logic [1:0] {StIdle, StPayload, StDrain} state_e;

    // Header fields always live in the low 32 bits; narrow buses are zero-extended.
    logic [31:0] hdr_w;
    if (DATA_W >= 32) begin : g_hdr_wide
        assign hdr_w = I_hs_data[31:0];
    end else begin : g_hdr_narrow
        assign hdr_w = {{(32 - DATA_W){1'b0}}, I_hs_data};
    end

    logic [1:0]  hdr_vc;
    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;
    logic [16:0] wc_words;
    logic        is_long;
    logic        vc_ok;
    logic        ecc_ok;
    logic        valid_1d_q;
    logic        hdr_det;

    assign hdr_vc   = hdr_w[31:30];
    assign hdr_dt   = hdr_w[29:24];
    assign hdr_wc   = {hdr_w[15:8], hdr_w[23:16]};
    assign is_long  = (hdr_dt >= 6'h10);
    assign wc_words = ({1'b0, hdr_wc} + 17'(BYTES - 1)) >> SHIFT;
    assign vc_ok    = (32'(hdr_vc) < NUM_VC) && I_vc_mask[hdr_vc];
    assign hdr_det  = I_hs_valid & ~valid_1d_q;

`ifdef CSI_ECC_CHECK_EN
    // Hamming parity over {WC_hi, WC_lo, DI}; each mask selects the data bits of one parity.
    function automatic logic [5:0] calc_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return p;
    endfunction

    logic err_ecc_q;
    assign ecc_ok    = (calc_ecc({hdr_w[15:8], hdr_w[23:16], hdr_w[31:24]}) == hdr_w[5:0]) &&
                       (hdr_w[7:6] == 2'b00);
    assign O_err_ecc = err_ecc_q;
`else
    logic unused_ecc;
    assign ecc_ok     = 1'b1;
    assign unused_ecc = ^hdr_w[7:0];
`endif

    state_e              state_q;
    logic [16:0]         remaining_q;
    logic                fwd_q;
    logic                first_q;
    logic [1:0]          cur_vc_q;
    logic [NUM_VC-1:0]   frame_active_q;
    logic [LCNT_W-1:0]   line_cnt_q [NUM_VC];
    logic                fs_q, fe_q, ls_q, valid_q, last_q, trunc_q, seq_q;
    logic [DATA_W-1:0]   data_q;
    logic [1:0]          vc_o_q;
    logic [LCNT_W-1:0]   lcnt_o_q;

    function automatic logic [LCNT_W-1:0] sat_inc(input logic [LCNT_W-1:0] v);
        return (v == {LCNT_W{1'b1}}) ? v : v + LCNT_W'(1);
    endfunction

    // Packet FSM, per-VC frame state and all registered outputs.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            // Held high so a packet already in flight at reset release is not seen as a header.
            valid_1d_q     <= 1'b1;
            state_q        <= StIdle;
            remaining_q    <= '0;
            fwd_q          <= 1'b0;
            first_q        <= 1'b0;
            cur_vc_q       <= '0;
            frame_active_q <= '0;
            for (int i = 0; i < NUM_VC; i++) line_cnt_q[i] <= '0;
            fs_q      <= 1'b0;
            fe_q      <= 1'b0;
            ls_q      <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            trunc_q   <= 1'b0;
            seq_q     <= 1'b0;
            data_q    <= '0;
            vc_o_q    <= '0;
            lcnt_o_q  <= '0;
`ifdef CSI_ECC_CHECK_EN
            err_ecc_q <= 1'b0;
`endif
        end else begin
            valid_1d_q <= I_hs_valid;
            fs_q       <= 1'b0;
            fe_q       <= 1'b0;
            ls_q       <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            trunc_q    <= 1'b0;
            seq_q      <= 1'b0;
            data_q     <= '0;
`ifdef CSI_ECC_CHECK_EN
            err_ecc_q  <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (hdr_det) begin
                        if (!ecc_ok) begin
`ifdef CSI_ECC_CHECK_EN
                            err_ecc_q <= 1'b1;
`endif
                            if (is_long) state_q <= StDrain;
                        end else if (is_long) begin
                            if (wc_words != 17'd0) begin
                                state_q     <= StPayload;
                                fwd_q       <= (hdr_dt == DATA_DT) && vc_ok;
                                remaining_q <= wc_words;
                                first_q     <= 1'b1;
                                cur_vc_q    <= hdr_vc;
                            end
                        end else if (vc_ok) begin
                            if (hdr_dt == 6'h00) begin
                                fs_q                   <= 1'b1;
                                seq_q                  <= frame_active_q[hdr_vc];
                                frame_active_q[hdr_vc] <= 1'b1;
                                line_cnt_q[hdr_vc]     <= '0;
                                vc_o_q                 <= hdr_vc;
                                lcnt_o_q               <= '0;
                            end else if (hdr_dt == 6'h01) begin
                                fe_q                   <= 1'b1;
                                seq_q                  <= ~frame_active_q[hdr_vc];
                                frame_active_q[hdr_vc] <= 1'b0;
                                vc_o_q                 <= hdr_vc;
                                lcnt_o_q               <= line_cnt_q[hdr_vc];
                            end
                        end
                    end
                end
                StPayload: begin
                    if (I_hs_valid) begin
                        remaining_q <= remaining_q - 17'd1;
                        first_q     <= 1'b0;
                        if (fwd_q) begin
                            valid_q  <= 1'b1;
                            data_q   <= I_hs_data;
                            ls_q     <= first_q;
                            last_q   <= (remaining_q == 17'd1);
                            vc_o_q   <= cur_vc_q;
                            lcnt_o_q <= line_cnt_q[cur_vc_q];
                        end
                        if (remaining_q == 17'd1) begin
                            state_q <= StDrain;
                            if (fwd_q) line_cnt_q[cur_vc_q] <= sat_inc(line_cnt_q[cur_vc_q]);
                        end
                    end else begin
                        state_q <= StIdle;
                        if (fwd_q) begin
                            trunc_q              <= 1'b1;
                            line_cnt_q[cur_vc_q] <= sat_inc(line_cnt_q[cur_vc_q]);
                        end
                    end
                end
                StDrain: begin
                    if (!I_hs_valid) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign O_frame_start = fs_q;
    assign O_frame_end   = fe_q;
    assign O_line_start  = ls_q;
    assign O_valid       = valid_q;
    assign O_data        = data_q;
    assign O_last        = last_q;
    assign O_vc          = vc_o_q;
    assign O_line_cnt    = lcnt_o_q;
    assign O_err_trunc   = trunc_q;
    assign O_err_seq     = seq_q;

endmodule

// File: tb/tb_csi_packet_parser_vc.sv
// Directed self-checking bench for csi_packet_parser_vc (DATA_W = 32, NUM_VC = 4).
module tb_csi_packet_parser_vc;

    logic        I_clk = 1'b0;
    logic        I_rst = 1'b1;
    logic        I_hs_valid = 1'b0;
    logic [31:0] I_hs_data = '0;
    logic [3:0]  I_vc_mask = 4'hF;
    logic        O_frame_start, O_frame_end, O_line_start, O_valid, O_last;
    logic [31:0] O_data;
    logic [1:0]  O_vc;
    logic [15:0] O_line_cnt;
    logic        O_err_trunc, O_err_seq;
`ifdef CSI_ECC_CHECK_EN
    logic        O_err_ecc;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        int nvalid; int nlast; int last_idx; int ls_idx; int nls;
        int ntrunc; int err; int lcnt; int necc;
    } obs_t;

    csi_packet_parser_vc dut (
        .I_clk        (I_clk),
        .I_rst        (I_rst),
        .I_hs_valid   (I_hs_valid),
        .I_hs_data    (I_hs_data),
        .I_vc_mask    (I_vc_mask),
        .O_frame_start(O_frame_start),
        .O_frame_end  (O_frame_end),
        .O_line_start (O_line_start),
        .O_valid      (O_valid),
        .O_data       (O_data),
        .O_last       (O_last),
        .O_vc         (O_vc),
        .O_line_cnt   (O_line_cnt),
        .O_err_trunc  (O_err_trunc),
        .O_err_seq    (O_err_seq)
`ifdef CSI_ECC_CHECK_EN
        ,
        .O_err_ecc    (O_err_ecc)
`endif
    );

    always #5 I_clk = ~I_clk;

    function automatic logic [5:0] ecc6(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    function automatic logic [31:0] mk_hdr(input logic [1:0] vc, input logic [5:0] dt,
                                           input logic [15:0] wc, input bit bad);
        logic [7:0] di;
        logic [5:0] e;
        di = {vc, dt};
        e  = ecc6({wc[15:8], wc[7:0], di});
        if (bad) e[0] = ~e[0];
        return {di, wc[7:0], wc[15:8], 2'b00, e};
    endfunction

    function automatic obs_t exp_obs(input int nvalid, input int last_idx, input int ls_idx,
                                     input int ntrunc, input int lcnt, input int necc);
        obs_t o;
        o.nvalid = nvalid;  o.nlast = (last_idx != 0) ? 1 : 0; o.last_idx = last_idx;
        o.ls_idx = ls_idx;  o.nls = (ls_idx != 0) ? 1 : 0;     o.ntrunc = ntrunc;
        o.err = 0;          o.lcnt = lcnt;                     o.necc = necc;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("valid=%0d last=%0d@%0d ls=%0d@%0d trunc=%0d err=%0d lcnt=%0d ecc=%0d",
                         o.nvalid, o.nlast, o.last_idx, o.nls, o.ls_idx, o.ntrunc, o.err,
                         o.lcnt, o.necc);
    endfunction

    // Drive one word; outputs sampled at the following negedge reflect it.
    task automatic cyc(input logic v, input logic [31:0] d);
        I_hs_valid = v;
        I_hs_data  = d;
        @(negedge I_clk);
    endtask

    // Header, nsend payload words, then one idle cycle; tallies what the DUT emits.
    task automatic drive_long(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                              input int nsend, input bit bad, output obs_t o);
        o = '0;
        o.lcnt = -1;
        for (int i = 0; i <= nsend + 1; i++) begin
            if (i == 0) cyc(1'b1, mk_hdr(vc, dt, wc, bad));
            else if (i <= nsend) cyc(1'b1, 32'hBEEF_0000 | 32'(i));
            else cyc(1'b0, 32'h0);
            if (O_valid) begin
                o.nvalid++;
                if (O_data !== (32'hBEEF_0000 | 32'(o.nvalid))) o.err++;
                if (O_vc !== vc) o.err++;
                if (o.nvalid == 1) o.lcnt = int'(O_line_cnt);
                if (O_last) begin o.nlast++; o.last_idx = o.nvalid; end
            end else if (O_data !== 32'h0) begin
                o.err++;
            end
            if (O_line_start) begin o.nls++; o.ls_idx = O_valid ? o.nvalid : -1; end
            if (O_frame_start || O_frame_end || O_err_seq) o.err++;
            if (O_err_trunc) o.ntrunc++;
`ifdef CSI_ECC_CHECK_EN
            if (O_err_ecc) o.necc++;
`endif
        end
    endtask

    task automatic drive_short(input logic [1:0] vc, input logic [5:0] dt, input bit bad,
                               output logic [2:0] marks, output logic [1:0] vco, output int necc);
        cyc(1'b1, mk_hdr(vc, dt, 16'h0, bad));
        marks = {O_frame_start, O_frame_end, O_err_seq};
        vco   = O_vc;
        necc  = 0;
`ifdef CSI_ECC_CHECK_EN
        necc  = int'(O_err_ecc);
`endif
        cyc(1'b0, 32'h0);
    endtask

    task automatic test_reset();
        I_rst = 1'b1; I_hs_valid = 1'b0; I_hs_data = '0;
        repeat (2) @(negedge I_clk);
        tests++;
        if ({O_frame_start, O_frame_end, O_line_start, O_valid, O_last, O_err_trunc, O_err_seq,
             O_data, O_vc, O_line_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b data=%h vc=%0d lcnt=%0d, want all 0",
                     O_valid, O_data, O_vc, O_line_cnt);
        end
        I_rst = 1'b0;
        repeat (2) @(negedge I_clk);
        tests++;
        if ({O_frame_start, O_frame_end, O_valid, O_err_trunc, O_err_seq} !== 5'b0) begin
            fails++;
            $display("FAIL idle_after_reset: got fs=%b fe=%b valid=%b, want 0", O_frame_start,
                     O_frame_end, O_valid);
        end
    endtask

    task automatic test_frame_lines();
        logic [2:0] m; logic [1:0] v; int ne; obs_t o;
        drive_short(2'd0, 6'h00, 1'b0, m, v, ne);
        tests++;
        if ({m, v} !== {3'b100, 2'd0}) begin
            fails++; $display("FAIL fs_vc0: got fs/fe/seq=%b vc=%0d, want 100 vc=0", m, v);
        end
        for (int l = 0; l < 3; l++) begin
            drive_long(2'd0, 6'h2B, 16'd40, 10, 1'b0, o);
            tests++;
            if (o !== exp_obs(10, 10, 1, 0, l, 0)) begin
                fails++;
                $display("FAIL line%0d: got %s, want %s", l, fmt(o), fmt(exp_obs(10, 10, 1, 0, l, 0)));
            end
        end
        drive_short(2'd0, 6'h01, 1'b0, m, v, ne);
        tests++;
        if (m !== 3'b010) begin
            fails++; $display("FAIL fe_vc0: got fs/fe/seq=%b, want 010", m);
        end
    endtask

    task automatic test_wc_rounding();
        logic [2:0] m; logic [1:0] v; int ne; obs_t o;
        drive_short(2'd0, 6'h00, 1'b0, m, v, ne);
        drive_long(2'd0, 6'h2B, 16'd42, 13, 1'b0, o);
        tests++;
        if (o !== exp_obs(11, 11, 1, 0, 0, 0)) begin
            fails++; $display("FAIL wc42: got %s, want %s", fmt(o), fmt(exp_obs(11, 11, 1, 0, 0, 0)));
        end
        drive_long(2'd0, 6'h2B, 16'd0, 2, 1'b0, o);
        tests++;
        if (o !== exp_obs(0, 0, 0, 0, -1, 0)) begin
            fails++; $display("FAIL wc0: got %s, want %s", fmt(o), fmt(exp_obs(0, 0, 0, 0, -1, 0)));
        end
        drive_long(2'd0, 6'h2B, 16'd5, 3, 1'b0, o);
        tests++;
        if (o !== exp_obs(2, 2, 1, 0, 1, 0)) begin
            fails++; $display("FAIL wc5: got %s, want %s", fmt(o), fmt(exp_obs(2, 2, 1, 0, 1, 0)));
        end
        drive_short(2'd0, 6'h01, 1'b0, m, v, ne);
        tests++;
        if (m !== 3'b010) begin
            fails++; $display("FAIL fe_wc: got fs/fe/seq=%b, want 010", m);
        end
    endtask

    task automatic test_other_dt();
        logic [2:0] m; logic [1:0] v; int ne; obs_t o;
        drive_short(2'd0, 6'h00, 1'b0, m, v, ne);
        drive_long(2'd0, 6'h2A, 16'd40, 10, 1'b0, o);
        tests++;
        if (o !== exp_obs(0, 0, 0, 0, -1, 0)) begin
            fails++; $display("FAIL dt2a_dropped: got %s, want %s", fmt(o), fmt(exp_obs(0, 0, 0, 0, -1, 0)));
        end
        drive_long(2'd0, 6'h2B, 16'd40, 10, 1'b0, o);
        tests++;
        if (o !== exp_obs(10, 10, 1, 0, 0, 0)) begin
            fails++; $display("FAIL after_dt2a: got %s, want %s", fmt(o), fmt(exp_obs(10, 10, 1, 0, 0, 0)));
        end
        drive_short(2'd0, 6'h01, 1'b0, m, v, ne);
    endtask

    task automatic test_vc_mask();
        logic [2:0] m; logic [1:0] v; int ne; obs_t o;
        I_vc_mask = 4'b0001;
        drive_short(2'd1, 6'h00, 1'b0, m, v, ne);
        tests++;
        if (m !== 3'b000) begin fails++; $display("FAIL fs_vc1_masked: got %b, want 000", m); end
        drive_short(2'd0, 6'h00, 1'b0, m, v, ne);
        tests++;
        if ({m, v} !== {3'b100, 2'd0}) begin
            fails++; $display("FAIL fs_vc0_mask: got %b vc=%0d, want 100 vc=0", m, v);
        end
        drive_long(2'd1, 6'h2B, 16'd40, 10, 1'b0, o);
        tests++;
        if (o !== exp_obs(0, 0, 0, 0, -1, 0)) begin
            fails++; $display("FAIL line_vc1_masked: got %s, want %s", fmt(o), fmt(exp_obs(0, 0, 0, 0, -1, 0)));
        end
        drive_long(2'd0, 6'h2B, 16'd40, 10, 1'b0, o);
        tests++;
        if (o !== exp_obs(10, 10, 1, 0, 0, 0)) begin
            fails++; $display("FAIL line_vc0_mask: got %s, want %s", fmt(o), fmt(exp_obs(10, 10, 1, 0, 0, 0)));
        end
        drive_short(2'd1, 6'h01, 1'b0, m, v, ne);
        tests++;
        if (m !== 3'b000) begin fails++; $display("FAIL fe_vc1_masked: got %b, want 000", m); end
        drive_short(2'd0, 6'h01, 1'b0, m, v, ne);
        tests++;
        if (m !== 3'b010) begin fails++; $display("FAIL fe_vc0_mask: got %b, want 010", m); end
        I_vc_mask = 4'hF;
    endtask

    task automatic test_interleave();
        logic [2:0] m; logic [1:0] v; int ne; obs_t o;
        drive_short(2'd0, 6'h00, 1'b0, m, v, ne);
        drive_short(2'd1, 6'h00, 1'b0, m, v, ne);
        tests++;
        if ({m, v} !== {3'b100, 2'd1}) begin
            fails++; $display("FAIL fs_vc1: got %b vc=%0d, want 100 vc=1", m, v);
        end
        for (int l = 0; l < 4; l++) begin
            drive_long(2'(l % 2), 6'h2B, 16'd8, 2, 1'b0, o);
            tests++;
            if (o !== exp_obs(2, 2, 1, 0, l / 2, 0)) begin
                fails++;
                $display("FAIL ilv_line%0d: got %s, want %s", l, fmt(o), fmt(exp_obs(2, 2, 1, 0, l / 2, 0)));
            end
        end
        drive_short(2'd1, 6'h01, 1'b0, m, v, ne);
        tests++;
        if ({m, v} !== {3'b010, 2'd1}) begin
            fails++; $display("FAIL fe_vc1: got %b vc=%0d, want 010 vc=1", m, v);
        end
        drive_short(2'd0, 6'h01, 1'b0, m, v, ne);
        tests++;
        if ({m, v} !== {3'b010, 2'd0}) begin
            fails++; $display("FAIL fe_vc0_ilv: got %b vc=%0d, want 010 vc=0", m, v);
        end
    endtask

    task automatic test_trunc();
        logic [2:0] m; logic [1:0] v; int ne; obs_t o;
        drive_short(2'd0, 6'h00, 1'b0, m, v, ne);
        drive_long(2'd0, 6'h2B, 16'd40, 4, 1'b0, o);
        tests++;
        if (o !== exp_obs(4, 0, 1, 1, 0, 0)) begin
            fails++; $display("FAIL trunc4: got %s, want %s", fmt(o), fmt(exp_obs(4, 0, 1, 1, 0, 0)));
        end
        drive_long(2'd0, 6'h2B, 16'd40, 10, 1'b0, o);
        tests++;
        if (o !== exp_obs(10, 10, 1, 0, 1, 0)) begin
            fails++; $display("FAIL after_trunc: got %s, want %s", fmt(o), fmt(exp_obs(10, 10, 1, 0, 1, 0)));
        end
        drive_short(2'd0, 6'h00, 1'b0, m, v, ne);
        tests++;
        if (m !== 3'b101) begin fails++; $display("FAIL fs_while_active: got %b, want 101", m); end
        drive_long(2'd0, 6'h2B, 16'd40, 10, 1'b0, o);
        tests++;
        if (o !== exp_obs(10, 10, 1, 0, 0, 0)) begin
            fails++; $display("FAIL restart_lcnt: got %s, want %s", fmt(o), fmt(exp_obs(10, 10, 1, 0, 0, 0)));
        end
        drive_short(2'd0, 6'h01, 1'b0, m, v, ne);
        tests++;
        if (m !== 3'b010) begin fails++; $display("FAIL fe_trunc: got %b, want 010", m); end
        drive_short(2'd0, 6'h01, 1'b0, m, v, ne);
        tests++;
        if (m !== 3'b011) begin fails++; $display("FAIL fe_while_idle: got %b, want 011", m); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] m; logic [1:0] v; int ne; obs_t o; int bad;
        drive_short(2'd0, 6'h00, 1'b0, m, v, ne);
        drive_long(2'd0, 6'h2B, 16'd40, 10, 1'b0, o);
        cyc(1'b1, mk_hdr(2'd0, 6'h2B, 16'd40, 1'b0));
        cyc(1'b1, 32'hBEEF_0001);
        cyc(1'b1, 32'hBEEF_0002);
        tests++;
        if (O_valid !== 1'b1) begin fails++; $display("FAIL mid_payload_valid: got %b, want 1", O_valid); end
        I_rst = 1'b1;
        #1;
        tests++;
        if ({O_valid, O_last, O_line_start, O_data, O_line_cnt} !== '0) begin
            fails++; $display("FAIL async_reset: got valid=%b data=%h, want 0", O_valid, O_data);
        end
        cyc(1'b1, mk_hdr(2'd0, 6'h00, 16'd0, 1'b0));
        I_rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, mk_hdr(2'd0, 6'h00, 16'd0, 1'b0));
            if (O_frame_start || O_valid || O_err_seq) bad++;
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL held_valid_no_hdr: got %0d events, want 0", bad); end
        cyc(1'b0, 32'h0);
        drive_long(2'd0, 6'h2B, 16'd40, 10, 1'b0, o);
        tests++;
        if (o !== exp_obs(10, 10, 1, 0, 0, 0)) begin
            fails++; $display("FAIL post_reset_line: got %s, want %s", fmt(o), fmt(exp_obs(10, 10, 1, 0, 0, 0)));
        end
        drive_short(2'd0, 6'h01, 1'b0, m, v, ne);
        tests++;
        if (m !== 3'b011) begin fails++; $display("FAIL post_reset_fe: got %b, want 011", m); end
    endtask

`ifdef CSI_ECC_CHECK_EN
    task automatic test_ecc();
        logic [2:0] m; logic [1:0] v; int ne; obs_t o;
        drive_short(2'd0, 6'h00, 1'b1, m, v, ne);
        tests++;
        if (m !== 3'b000 || ne !== 1) begin
            fails++; $display("FAIL ecc_bad_fs: got %b ecc=%0d, want 000 ecc=1", m, ne);
        end
        drive_short(2'd0, 6'h00, 1'b0, m, v, ne);
        tests++;
        if (m !== 3'b100 || ne !== 0) begin
            fails++; $display("FAIL ecc_good_fs: got %b ecc=%0d, want 100 ecc=0", m, ne);
        end
        drive_long(2'd0, 6'h2B, 16'd40, 10, 1'b1, o);
        tests++;
        if (o !== exp_obs(0, 0, 0, 0, -1, 1)) begin
            fails++; $display("FAIL ecc_bad_line: got %s, want %s", fmt(o), fmt(exp_obs(0, 0, 0, 0, -1, 1)));
        end
        drive_long(2'd0, 6'h2B, 16'd40, 10, 1'b0, o);
        tests++;
        if (o !== exp_obs(10, 10, 1, 0, 0, 0)) begin
            fails++; $display("FAIL ecc_good_line: got %s, want %s", fmt(o), fmt(exp_obs(10, 10, 1, 0, 0, 0)));
        end
        drive_short(2'd0, 6'h01, 1'b0, m, v, ne);
    endtask
`endif

    initial begin
        test_reset();
        test_frame_lines();
        test_wc_rounding();
        test_other_dt();
        test_vc_mask();
        test_interleave();
        test_trunc();
        test_reset_mid();
`ifdef CSI_ECC_CHECK_EN
        test_ecc();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
